dict_search_ctrl: RTL and testbench

Sequencing controller for the dictionary search engine in the compression datapath. It accepts an input byte stream and issues one chained lookup per byte to the search engine. Each byte produces one output token: a match index on a hit, or a literal on a miss. On a miss the byte is also inserted into the dictionary with FIFO replacement. The controller owns both the engine's search port and the dictionary write port, so lookups and inserts never overlap.

---
 rtl/dict_search_ctrl.sv | 153 +++++++++++++++
 tb/tb_dict_search_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dict_search_ctrl.sv
// Sequencing controller for the dictionary search engine: one chained lookup per
// input byte, emits a match/literal token, and inserts misses with FIFO replacement.
module dict_search_ctrl #(
  parameter int unsigned KEY_W        = 8,
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned CHAIN_LENGTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_data,
  input  logic             in_last,
  output logic             srch_start,
  output logic [KEY_W-1:0] srch_key,
  input  logic             srch_done,
  input  logic             srch_hit,
  input  logic [IDX_W-1:0] srch_idx,
  output logic             dict_we,
  output logic [IDX_W-1:0] dict_waddr,
  output logic [KEY_W-1:0] dict_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_match,
  output logic [KEY_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [7:0]       timeout_cnt
);

  localparam int unsigned CNT_W  = $clog2(CHAIN_LENGTH + 2);
  localparam int unsigned FILL_W = IDX_W + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(2 ** IDX_W);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(CHAIN_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT,
    S_EMIT,
    S_INSERT
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                last_q, last_d;
  logic                match_q, match_d;
  logic [KEY_W-1:0]    odata_q, odata_d;
  logic [IDX_W-1:0]    wptr_q, wptr_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [7:0]          tmo_q, tmo_d;

  // State, datapath and registered control outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      last_q     <= 1'b0;
      match_q    <= 1'b0;
      odata_q    <= '0;
      wptr_q     <= '0;
      fill_q     <= '0;
      wcnt_q     <= '0;
      tmo_q      <= '0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      srch_start <= 1'b0;
      dict_we    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      last_q     <= last_d;
      match_q    <= match_d;
      odata_q    <= odata_d;
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      wcnt_q     <= wcnt_d;
      tmo_q      <= tmo_d;
      in_ready   <= (state_d == S_IDLE);
      busy       <= (state_d != S_IDLE);
      srch_start <= (state_d == S_LOOKUP) && (fill_q != '0);
      dict_we    <= (state_d == S_INSERT);
      out_valid  <= (state_d == S_EMIT);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    last_d  = last_q;
    match_d = match_q;
    odata_d = odata_q;
    wptr_d  = wptr_q;
    fill_d  = fill_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          key_d   = in_data;
          last_d  = in_last;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (fill_q == '0) begin
          match_d = 1'b0;
          odata_d = key_q;
          state_d = S_EMIT;
        end else begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (srch_done) begin
          match_d = srch_hit;
          odata_d = srch_hit ? KEY_W'(srch_idx) : key_q;
          state_d = S_EMIT;
        end else if (wcnt_q == WAIT_LAST) begin
          // Engine never answered: treat as a miss
          match_d = 1'b0;
          odata_d = key_q;
          if (tmo_q != 8'hff) tmo_d = tmo_q + 8'd1;
          state_d = S_EMIT;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) state_d = match_q ? S_IDLE : S_INSERT;
      end
      S_INSERT: begin
        wptr_d = wptr_q + IDX_W'(1);
        if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign srch_key     = key_q;
  assign dict_wdata   = key_q;
  assign dict_waddr   = wptr_q;
  assign out_is_match = match_q;
  assign out_data     = odata_q;
  assign out_last     = last_q;
  assign timeout_cnt  = tmo_q;

endmodule

// File: tb/tb_dict_search_ctrl.sv
// Self-checking bench for dict_search_ctrl; the bench plays the search engine from
// its own model of the dictionary contents and FIFO replacement.
module tb_dict_search_ctrl;

  localparam int unsigned KEY_W = 8;
  localparam int unsigned IDX_W = 4;
  localparam int          CL    = 4;
  localparam int          DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [KEY_W-1:0] in_data;
  logic             in_last;
  logic             srch_start;
  logic [KEY_W-1:0] srch_key;
  logic             srch_done;
  logic             srch_hit;
  logic [IDX_W-1:0] srch_idx;
  logic             dict_we;
  logic [IDX_W-1:0] dict_waddr;
  logic [KEY_W-1:0] dict_wdata;
  logic             out_valid;
  logic             out_ready;
  logic             out_is_match;
  logic [KEY_W-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic [7:0]       timeout_cnt;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mdict [DEPTH];
  int mfill = 0;
  int mwptr = 0;
  int mtmo  = 0;

  dict_search_ctrl #(.KEY_W(KEY_W), .IDX_W(IDX_W), .CHAIN_LENGTH(CL)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .srch_start(srch_start), .srch_key(srch_key), .srch_done(srch_done),
    .srch_hit(srch_hit), .srch_idx(srch_idx),
    .dict_we(dict_we), .dict_waddr(dict_waddr), .dict_wdata(dict_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_match(out_is_match),
    .out_data(out_data), .out_last(out_last), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mfill = 0;
    mwptr = 0;
    mtmo  = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_srch_start"}, 32'(srch_start), 32'(0));
    check({tag, "_dict_we"}, 32'(dict_we), 32'(0));
  endtask

  // One byte end to end. d = engine delay in WAIT cycles (0..CL), or -1 for no reply.
  task automatic send_byte(input logic [7:0] b, input logic lst, input int d, input int bp);
    int         hit_idx;
    logic       exp_hit;
    logic [7:0] exp_data;
    hit_idx = -1;
    for (int i = 0; i < mfill; i++)
      if (hit_idx < 0 && mdict[i] == b) hit_idx = i;
    exp_hit  = (mfill > 0) && (d >= 0) && (hit_idx >= 0);
    exp_data = exp_hit ? 8'(hit_idx) : b;

    check("accept_in_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    in_data  = b;
    in_last  = lst;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
    check("lookup_srch_start", 32'(srch_start), 32'(mfill > 0));
    check("lookup_busy", 32'(busy), 32'(1));
    check("lookup_in_ready", 32'(in_ready), 32'(0));
    if (mfill > 0) begin
      check("lookup_srch_key", 32'(srch_key), 32'(b));
      tick();
      if (d >= 0) begin
        for (int k = 0; k < d; k++) begin
          check("wait_no_valid", 32'(out_valid), 32'(0));
          tick();
        end
        srch_done = 1'b1;
        srch_hit  = exp_hit;
        srch_idx  = exp_hit ? 4'(hit_idx) : 4'($urandom);
        check("wait_srch_key", 32'(srch_key), 32'(b));
        check("wait_srch_start", 32'(srch_start), 32'(0));
        tick();
        srch_done = 1'b0;
        srch_hit  = 1'($urandom);
      end else begin
        for (int k = 0; k <= CL; k++) begin
          check("timeout_no_valid", 32'(out_valid), 32'(0));
          tick();
        end
        if (mtmo < 255) mtmo = mtmo + 1;
      end
    end else begin
      tick();
    end

    check("tok_valid", 32'(out_valid), 32'(1));
    check("tok_is_match", 32'(out_is_match), 32'(exp_hit));
    check("tok_data", 32'(out_data), 32'(exp_data));
    check("tok_last", 32'(out_last), 32'(lst));
    check("tok_timeout_cnt", 32'(timeout_cnt), 32'(mtmo));
    for (int k = 0; k < bp; k++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'(1));
      check("bp_fields", {22'd0, out_is_match, out_last, out_data},
            {22'd0, exp_hit, lst, exp_data});
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_dict_we", 32'(dict_we), 32'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'(0));
    if (exp_hit) begin
      check("hit_in_ready", 32'(in_ready), 32'(1));
      check("hit_no_dict_we", 32'(dict_we), 32'(0));
    end else begin
      check("ins_dict_we", 32'(dict_we), 32'(1));
      check("ins_waddr", 32'(dict_waddr), 32'(mwptr));
      check("ins_wdata", 32'(dict_wdata), 32'(b));
      check("ins_srch_start", 32'(srch_start), 32'(0));
      check("ins_in_ready", 32'(in_ready), 32'(0));
      mdict[mwptr] = b;
      mwptr = (mwptr + 1) % DEPTH;
      if (mfill < DEPTH) mfill = mfill + 1;
      tick();
      check("ins_done_in_ready", 32'(in_ready), 32'(1));
      check("ins_done_dict_we", 32'(dict_we), 32'(0));
      check("ins_wptr_next", 32'(dict_waddr), 32'(mwptr));
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    srch_done = 1'b0;
    srch_hit  = 1'b0;
    srch_idx  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();

    // Reset state
    check_idle("rst");
    check("rst_timeout_cnt", 32'(timeout_cnt), 32'(0));
    check("rst_waddr", 32'(dict_waddr), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_is_match", 32'(out_is_match), 32'(0));

    // Empty dictionary, then hit on the inserted byte
    send_byte(8'h41, 1'b0, 1, 0);
    send_byte(8'h41, 1'b1, 1, 0);

    // Wrap of the replacement pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i <= 16; i++)
      send_byte(8'(i), 1'($urandom), int'($urandom_range(0, CL)), int'($urandom_range(0, 2)));

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      int d;
      d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, CL));
      send_byte(8'($urandom_range(0, 31)), 1'($urandom), d, int'($urandom_range(0, 3)));
    end

    // Timeout, then a late result pulse in IDLE
    send_byte(8'h05, 1'b0, -1, 0);
    srch_done = 1'b1;
    srch_hit  = 1'b1;
    srch_idx  = 4'd3;
    tick();
    srch_done = 1'b0;
    check_idle("late_done");
    tick();
    check_idle("late_done2");
    check("late_timeout_cnt", 32'(timeout_cnt), 32'(mtmo));

    // Boundary: result in the final WAIT cycle, and long backpressure
    send_byte(8'h07, 1'b0, CL, 0);
    check("final_wait_no_timeout", 32'(timeout_cnt), 32'(mtmo));
    send_byte(8'h55, 1'b1, 2, 5);

    // Reset during WAIT discards the byte without a write
    in_valid = 1'b1;
    in_data  = 8'h66;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_idle("rst_wait");
    check("rst_wait_wptr", 32'(dict_waddr), 32'(0));
    check("rst_wait_tmo", 32'(timeout_cnt), 32'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_wait_no_we", 32'(dict_we), 32'(0));
    end
    send_byte(8'h41, 1'b0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
